point_tx_sender: RTL and testbench

- Transmit side of the serial vector-point link.
- Reads a list of 32-bit points from a point memory and sends one frame over a UART line (8N1):
  - 8 sync bytes of 0x00;
  - each point as 4 bytes, MSB first;
  - terminator 0x01010101.
- Sits between the point RAM / host-side logic and the serial pin feeding the downstream receive buffer.

---
 rtl/point_link_pkg.sv | 25 ++
 rtl/point_tx_sender_uart_tx.sv | 87 ++++++++
 rtl/point_tx_sender.sv | 180 ++++++++++++++++++
 tb/tb_point_tx_sender.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/point_link_pkg.sv
// Shared constants and state encodings for the serial vector-point link.
package point_link_pkg;

  localparam logic [7:0]  SYNC_BYTE       = 8'h00;
  localparam logic [31:0] TERM_WORD       = 32'h01010101;
  localparam logic [31:0] ESCAPE_WORD     = 32'h01010100;
  localparam int          DEFAULT_MAX_PTS = 20000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FETCH,
    ST_SEND,
    ST_TERM,
    ST_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/point_tx_sender_uart_tx.sv
// 8N1 UART transmitter; o_Tx_Done marks the final stop-bit cycle so a byte
// presented on i_Tx_DV in that cycle follows with no idle gap.
module uart_tx
  import point_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic          bit_end;

  assign bit_end     = (clk_cnt == LAST_CLK);
  assign o_Tx_Active = (state != UART_IDLE);
  assign o_Tx_Done   = (state == UART_STOP) && bit_end;

  // Data register shifts right so the current data bit is always data[0].
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= UART_IDLE;
      o_Tx_Serial <= 1'b1;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      data        <= '0;
    end else if (i_Tx_DV && (state == UART_IDLE || o_Tx_Done)) begin
      state       <= UART_START;
      o_Tx_Serial <= 1'b0;
      clk_cnt     <= '0;
      data        <= i_Tx_Byte;
    end else begin
      case (state)
        UART_IDLE: begin
          o_Tx_Serial <= 1'b1;
        end
        UART_START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            state       <= UART_DATA;
            o_Tx_Serial <= data[0];
            data        <= data >> 1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state       <= UART_STOP;
              o_Tx_Serial <= 1'b1;
            end else begin
              bit_idx     <= bit_idx + 1'b1;
              o_Tx_Serial <= data[0];
              data        <= data >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= UART_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/point_tx_sender.sv
// Frame sender: sync bytes, points MSB first, terminator, over uart_tx.
// Macro POINT_TX_TERM_ESCAPE_EN rewrites terminator-valued points and adds escaped_cnt.
module point_tx_sender
  import point_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 11,
  parameter int MAX_PTS      = DEFAULT_MAX_PTS,
  parameter int SYNC_LEN     = 8   // at least 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [14:0]       num_points,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
`ifdef POINT_TX_TERM_ESCAPE_EN
  , output logic [15:0]     escaped_cnt
`endif
);

  frame_state_t state;
  logic [14:0]  n_pts;
  logic [14:0]  idx;
  logic [14:0]  idx_next;
  logic [14:0]  n_clamped;
  logic [7:0]   byte_cnt;
  logic [31:0]  shreg;
  logic [31:0]  fetched;
  logic         fetch_wait;
  logic         load;
  logic [7:0]   tx_byte;
  logic         tx_done;
  logic         tx_active;

  assign n_clamped = ({17'd0, num_points} > 32'(MAX_PTS)) ? 15'(MAX_PTS) : num_points;
  assign idx_next  = idx + 15'd1;
  assign tx_byte   = (state == ST_SEND || state == ST_TERM) ? shreg[31:24] : SYNC_BYTE;

  always_comb begin
    fetched = rd_data;
`ifdef POINT_TX_TERM_ESCAPE_EN
    if (rd_data == TERM_WORD) fetched = ESCAPE_WORD;
`endif
  end

  // A new byte is handed to the UART either on frame start or in the final
  // stop-bit cycle of the previous byte, keeping the line gap-free.
  always_comb begin
    load = 1'b0;
    if (state == ST_IDLE) begin
      load = start && !tx_active;
    end else if (tx_done) begin
      case (state)
        ST_SYNC: load = (byte_cnt < 8'(SYNC_LEN));
        ST_SEND: load = 1'b1;
        ST_TERM: load = (byte_cnt < 8'd4);
        default: load = 1'b0;
      endcase
    end
  end

  // The next point is fetched while the last byte of the previous group is
  // still on the line, so SEND already holds it when that byte finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      n_pts      <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      fetch_wait <= 1'b0;
`ifdef POINT_TX_TERM_ESCAPE_EN
      escaped_cnt <= '0;
`endif
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            n_pts    <= n_clamped;
            idx      <= '0;
            byte_cnt <= 8'd1;
            busy     <= 1'b1;
            state    <= ST_SYNC;
`ifdef POINT_TX_TERM_ESCAPE_EN
            escaped_cnt <= '0;
`endif
          end
        end
        ST_SYNC: begin
          if (load) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(SYNC_LEN - 1)) begin
              if (n_pts != '0) begin
                state      <= ST_FETCH;
                rd_en      <= 1'b1;
                rd_addr    <= idx[ADDR_W-1:0];
                fetch_wait <= 1'b0;
              end else begin
                state    <= ST_TERM;
                byte_cnt <= '0;
                shreg    <= TERM_WORD;
              end
            end
          end
        end
        ST_FETCH: begin
          if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            shreg    <= fetched;
            byte_cnt <= '0;
            state    <= ST_SEND;
`ifdef POINT_TX_TERM_ESCAPE_EN
            if (rd_data == TERM_WORD) escaped_cnt <= escaped_cnt + 16'd1;
`endif
          end
        end
        ST_SEND: begin
          if (load) begin
            shreg    <= {shreg[23:0], 8'h00};
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'd3) begin
              idx <= idx_next;
              if (idx_next == n_pts) begin
                state    <= ST_TERM;
                byte_cnt <= '0;
                shreg    <= TERM_WORD;
              end else begin
                state      <= ST_FETCH;
                rd_en      <= 1'b1;
                rd_addr    <= idx_next[ADDR_W-1:0];
                fetch_wait <= 1'b0;
              end
            end
          end
        end
        ST_TERM: begin
          if (tx_done) begin
            if (byte_cnt < 8'd4) begin
              shreg    <= {shreg[23:0], 8'h00};
              byte_cnt <= byte_cnt + 8'd1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .i_Clock    (clk),
    .i_Reset    (reset),
    .i_Tx_DV    (load),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Serial(tx),
    .o_Tx_Active(tx_active),
    .o_Tx_Done  (tx_done)
  );

endmodule

// File: tb/tb_point_tx_sender.sv
// Directed bench for point_tx_sender: decodes the UART line and checks frames,
// timing, clamping, reset abort and start filtering (also POINT_TX_TERM_ESCAPE_EN).
module tb_point_tx_sender;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] num_points;
  logic [10:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_data = '0;
  logic        tx;
  logic        busy;
  logic        done;
`ifdef POINT_TX_TERM_ESCAPE_EN
  logic [15:0] escaped_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  point_tx_sender #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (11),
    .MAX_PTS     (5),
    .SYNC_LEN    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_points(num_points),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
`ifdef POINT_TX_TERM_ESCAPE_EN
    , .escaped_cnt(escaped_cnt)
`endif
  );

  // Point memory with one-cycle read latency, plus a log of requested addresses.
  logic [31:0] mem [0:2047];
  int rd_log[$];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rd_log.push_back(int'(rd_addr));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // UART decoder sampling mid-bit on the falling edge.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_sh = '0;
  int  rx_frame_err = 0;
  bit  rx_active = 0;
  int  rx_cnt = 0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt < 9 * CPB && rx_cnt >= CPB && (rx_cnt % CPB) == CPB / 2)
        rx_sh[rx_cnt / CPB - 1] = tx;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        if (tx !== 1'b1) rx_frame_err++;
        rx_q.push_back(rx_sh);
        rx_active = 0;
      end
    end
  end

  int accept_cyc = 0;
  int lat = -1;
  int busy_low = 0;
  int timed_out = 0;
  int d0 = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int n);
    @(negedge clk);
    num_points = 15'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic run_frame(input string tag, input int n, input int budget, input bit extra);
    lat = -1;
    busy_low = 0;
    d0 = done_cnt;
    apply_stimulus(n);
    check_output({tag, "_busy_accept"}, 32'(busy), 32'd1);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - accept_cyc;
        break;
      end
      if (busy !== 1'b1) busy_low++;
      if (extra) begin
        num_points = 15'd3;
        start = ((i % 97) == 40);
      end
    end
    if (extra) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    timed_out = (lat < 0) ? 1 : 0;
    check_output({tag, "_timeout"}, 32'(timed_out), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic build_expected(input int n);
    logic [31:0] w;
    int k;
    k = (n > 5) ? 5 : n;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < k; i++) begin
      w = mem[i];
`ifdef POINT_TX_TERM_ESCAPE_EN
      if (w == 32'h01010101) w = 32'h01010100;
`endif
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h01);
  endtask

  task automatic compare_frame(input string tag);
    check_output({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_output($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    check_output({tag, "_framing"}, 32'(rx_frame_err), 32'd0);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rd_log.delete();
    rx_frame_err = 0;
  endtask

  initial begin
    $display("[TB] point_tx_sender directed run, CLKS_PER_BIT=%0d", CPB);
    reset = 1'b1;
    start = 1'b0;
    num_points = '0;
    repeat (3) @(negedge clk);
    check_output("rst_tx", 32'(tx), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_rd_en", 32'(rd_en), 32'd0);
    check_output("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two points, hand-listed byte stream.
    mem[0] = 32'h12345678;
    mem[1] = 32'h0ABC0DEF;
    clear_logs();
    run_frame("two", 2, 2000, 0);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h12, 8'h34, 8'h56, 8'h78, 8'h0A, 8'hBC, 8'h0D, 8'hEF,
              8'h01, 8'h01, 8'h01, 8'h01};
    compare_frame("two");
    check_output("two_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_output("two_latency", 32'(lat), 32'd800);
    check_output("two_busy_low", 32'(busy_low), 32'd0);
    check_output("two_busy_after", 32'(busy), 32'd0);
    check_output("two_rd_cnt", 32'(rd_log.size()), 32'd2);
    check_output("two_rd_a0", 32'(rd_log[0]), 32'd0);
    check_output("two_rd_a1", 32'(rd_log[1]), 32'd1);

    // Empty frame: sync then terminator, no reads.
    clear_logs();
    run_frame("zero", 0, 2000, 0);
    build_expected(0);
    compare_frame("zero");
    check_output("zero_latency", 32'(lat), 32'd480);
    check_output("zero_rd_cnt", 32'(rd_log.size()), 32'd0);
    check_output("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Oversized request clamps to MAX_PTS=5.
    mem[2] = 32'hDEADBEEF;
    mem[3] = 32'h00FF00FF;
    mem[4] = 32'h80000001;
    mem[5] = 32'h55555555;
    clear_logs();
    run_frame("clamp", 25000, 3000, 0);
    build_expected(5);
    compare_frame("clamp");
    check_output("clamp_latency", 32'(lat), 32'd1280);
    check_output("clamp_rd_cnt", 32'(rd_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++)
      check_output($sformatf("clamp_rd_a%0d", i), 32'(rd_log[i]), 32'(i));

    // Reset while the third byte of point 0 is on the line.
    mem[0] = 32'hCAFEF00D;
    clear_logs();
    d0 = done_cnt;
    apply_stimulus(1);
    for (int i = 0; i < 1000 && rx_q.size() < 10; i++) @(negedge clk);
    check_output("abort_reached", 32'(rx_q.size()), 32'd10);
    repeat (3 * CPB) @(negedge clk);
    check_output("abort_tx_low", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_output("abort_tx", 32'(tx), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check_output("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_output("abort_truncated", 32'(rx_q.size()), 32'd10);

    mem[0] = 32'h12345678;
    clear_logs();
    run_frame("restart", 2, 2000, 0);
    build_expected(2);
    compare_frame("restart");
    check_output("restart_latency", 32'(lat), 32'd800);

    // Start pulses while busy and on the done cycle are ignored.
    mem[0] = 32'hA5C33C5A;
    clear_logs();
    run_frame("ignore", 1, 2000, 1);
    build_expected(1);
    compare_frame("ignore");
    check_output("ignore_latency", 32'(lat), 32'd640);
    check_output("ignore_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_output("ignore_busy", 32'(busy), 32'd0);

    // Point equal to the terminator word.
    mem[0] = 32'h01010101;
    clear_logs();
    run_frame("term", 1, 2000, 0);
    build_expected(1);
    compare_frame("term");
`ifdef POINT_TX_TERM_ESCAPE_EN
    check_output("term_b15_escaped", 32'(rx_q[15]), 32'h00);
    check_output("term_escaped_cnt", 32'(escaped_cnt), 32'd1);
`else
    check_output("term_b15_verbatim", 32'(rx_q[15]), 32'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
